tlc_sched: RTL and testbench
============================

TLC_SCHED -- requirements
Module: tlc_sched

Interface
REQ-001 SHALL have parameter GREEN_T, default 50, green dwell in clkdiv cycles (1..63).
REQ-002 SHALL have parameter AMBER_T, default 5, amber dwell in cycles (1..63).
REQ-003 SHALL have parameter ALLRED_T, default 2, all-red clearance in cycles (1..63).
REQ-004 SHALL have port clkdiv  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  4  per-side vehicle sensor, bit n = side n, level-sensitive.
REQ-007 SHALL have port emg_req  input  1  emergency preemption request, level-sensitive.
REQ-008 SHALL have port emg_side  input  2  side to serve during preemption, sampled while emg_req=1.
REQ-009 SHALL have port G  output  4  one-hot green lamp, registered.
REQ-010 SHALL have port O  output  4  one-hot amber lamp, registered.
REQ-011 SHALL have port R  output  4  red lamps, equal to ~(G|O).
REQ-012 SHALL have port side  output  2  index of the side currently owning the intersection.
REQ-013 SHALL have port preempt  output  1  high while the green is held by emergency preemption.

Function
REQ-014 SHALL implement states IDLE, GREEN, AMBER, ALLRED; 6-bit dwell counter cleared on every state entry.
REQ-015 IDLE: all lamps red; SHALL move to ALLRED on the first cycle any req bit is 1, selecting the winner per REQ-017.
REQ-016 GREEN SHALL last exactly GREEN_T cycles; at expiry, if any req bit of another side is 1, go to AMBER, else stay GREEN and restart the counter (extension).
REQ-017 Winner SHALL be round-robin: first set req bit scanning side+1, side+2, side+3 modulo 4; pointer after reset is 3, so side 0 has first priority.
REQ-018 AMBER SHALL last exactly AMBER_T cycles, then ALLRED; ALLRED SHALL last exactly ALLRED_T cycles, then GREEN on the winner latched at AMBER entry.
REQ-019 Winner SHALL be latched once and not re-evaluated if req changes during AMBER/ALLRED.
REQ-020 At most one bit of G|O SHALL ever be 1; G and O SHALL never be 1 on the same side simultaneously.
REQ-021 Lamp outputs SHALL change on the same edge as the state register (0-cycle decode of registered state).
REQ-022 Sensor bit of the current green side SHALL NOT count as a competing request.

Reset
REQ-023 rst=1 SHALL force state IDLE, counter 0, pointer 3, side=0, preempt=0, G=0, O=0, R=4'b1111 on the next edge, overriding any state including mid-AMBER.

Configuration
REQ-024 Macro TLC_SCHED_EMG_EN defined: emg_req=1 during GREEN of another side SHALL enter AMBER next cycle (green truncated), then ALLRED, then GREEN on emg_side with preempt=1.
REQ-025 With TLC_SCHED_EMG_EN: if emg_side already green, SHALL hold GREEN with preempt=1; GREEN SHALL not expire while emg_req=1; on emg_req fall, counter restarts and normal rules resume, pointer = emg_side.
REQ-026 With TLC_SCHED_EMG_EN: emg_req in AMBER/ALLRED SHALL override the latched winner with emg_side; in IDLE SHALL behave as a request on emg_side.
REQ-027 Without TLC_SCHED_EMG_EN: emg_req and emg_side SHALL be ignored, preempt tied 0.

Structure
REQ-028 Package tlc_pkg SHALL hold the state encoding constants, side index constants (0..3) and default timing constants.
REQ-029 Round-robin winner search SHALL be sub-module tlc_rr_pick (inputs req, pointer; outputs winner, any).

Verification
REQ-030 rst, req=0 for 20 cycles -> R=1111, G=O=0 throughout.
REQ-031 req=0001 from cycle 0 -> 2 all-red cycles, then G=0001 held indefinitely (extension every 50 cycles).
REQ-032 req=1111 constant -> greens cycle sides 0,1,2,3,0; each G 50 cycles, O 5, all-red 2; period 57 cycles per side.
REQ-033 side 0 green, req=0100 pulsed 1 cycle at count 10 then req=0 -> at expiry no switch (level sampled at expiry only).
REQ-034 TLC_SCHED_EMG_EN, side 0 green at count 10, emg_req=1, emg_side=2 -> O=0001 next cycle for 5, all-red 2, G=0100, preempt=1 until emg_req drops.
REQ-035 rst asserted during AMBER of side 1 -> next edge R=1111, G=O=0, state IDLE.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light scheduler: state encoding, side indices, default dwells.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_AMBER  = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  localparam logic [1:0] SIDE_0 = 2'd0;
  localparam logic [1:0] SIDE_1 = 2'd1;
  localparam logic [1:0] SIDE_2 = 2'd2;
  localparam logic [1:0] SIDE_3 = 2'd3;

  localparam int GREEN_T_DEF  = 50;
  localparam int AMBER_T_DEF  = 5;
  localparam int ALLRED_T_DEF = 2;
  localparam int CNT_W        = 6;

  // One-hot lamp vector for a side index.
  function automatic logic [3:0] side_oh(input logic [1:0] s);
    side_oh = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin winner search over four sides, nearest to pointer+1 wins, pointer itself last.
// Latency: combinational, 0 cycles.
// Backpressure: none; winner is meaningful only while any=1.
// Ports: req[3:0] candidate sides, pointer[1:0] last served side,
//        winner[1:0] chosen side, any = at least one candidate present.
module tlc_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] pointer,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the nearest set bit overwrites the result.
  always_comb begin
    winner = pointer;
    any    = 1'b0;
    idx    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = pointer + 2'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_sched.sv
// Four-way traffic-light scheduler: round-robin greens with amber and all-red clearance.
// Latency: lamps registered, change on the same edge as the state; decisions use inputs of the prior cycle.
// Backpressure: none; req/emg_req are level-sensitive and sampled only when a decision is due.
// Optional emergency preemption is built when macro TLC_SCHED_EMG_EN is defined.
// Ports: clkdiv clock, rst sync active-high reset, req[3:0] per-side sensors,
//        emg_req/emg_side preemption request, G/O/R[3:0] lamps, side[1:0] owner, preempt flag.
module tlc_sched
  import tlc_pkg::*;
#(
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int AMBER_T  = AMBER_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF
) (
  input  logic       clkdiv,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emg_req,
  input  logic [1:0] emg_side,
  output logic [3:0] G,
  output logic [3:0] O,
  output logic [3:0] R,
  output logic [1:0] side,
  output logic       preempt
);

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(AMBER_T - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ALLRED_T - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       ptr, nxt_ptr;
  logic [1:0]       win_q, nxt_win;
  logic [1:0]       nxt_side;
  logic             nxt_preempt;
  logic [3:0]       nxt_g, nxt_o;

  logic             emg_act;
  logic [3:0]       req_eff;
  logic [3:0]       pick_req;
  logic [1:0]       pick_win;
  logic             pick_any;

`ifdef TLC_SCHED_EMG_EN
  assign emg_act = emg_req;
`else
  logic unused_emg;
  assign emg_act    = 1'b0;
  assign unused_emg = emg_req;
`endif

  // An emergency in IDLE acts as an ordinary request on its side.
  assign req_eff = req | (emg_act ? side_oh(emg_side) : 4'b0000);

  // The green side's own sensor never competes against itself.
  assign pick_req = (state == ST_GREEN) ? (req_eff & ~side_oh(side)) : req_eff;

  tlc_rr_pick u_pick (
    .req     (pick_req),
    .pointer (ptr),
    .winner  (pick_win),
    .any     (pick_any)
  );

  always_ff @(posedge clkdiv) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ptr     <= SIDE_3;
      win_q   <= SIDE_0;
      side    <= SIDE_0;
      preempt <= 1'b0;
      G       <= 4'b0000;
      O       <= 4'b0000;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      ptr     <= nxt_ptr;
      win_q   <= nxt_win;
      side    <= nxt_side;
      preempt <= nxt_preempt;
      G       <= nxt_g;
      O       <= nxt_o;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_ptr   = ptr;
    nxt_win   = win_q;
    nxt_side  = side;

    case (state)
      ST_IDLE: begin
        nxt_cnt = '0;
        if (pick_any) begin
          nxt_state = ST_ALLRED;
          nxt_win   = pick_win;
        end
      end

      ST_GREEN: begin
        if (emg_act) begin
          nxt_cnt = '0;
          if (emg_side != side) begin
            nxt_state = ST_AMBER;
            nxt_win   = emg_side;
          end
        end else if (preempt) begin
          // Emergency just released: give the held side a fresh full green.
          nxt_cnt = '0;
        end else if (cnt == G_LAST) begin
          nxt_cnt = '0;
          if (pick_any) begin
            nxt_state = ST_AMBER;
            nxt_win   = pick_win;
          end
        end
      end

      ST_AMBER: begin
        if (emg_act) nxt_win = emg_side;
        if (cnt == A_LAST) begin
          nxt_state = ST_ALLRED;
          nxt_cnt   = '0;
        end
      end

      ST_ALLRED: begin
        if (emg_act) nxt_win = emg_side;
        if (cnt == R_LAST) begin
          nxt_state = ST_GREEN;
          nxt_cnt   = '0;
          nxt_side  = nxt_win;
          nxt_ptr   = nxt_win;
        end
      end

      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase

    // Lamps decoded from the next state so they register alongside it.
    nxt_g       = (nxt_state == ST_GREEN) ? side_oh(nxt_side) : 4'b0000;
    nxt_o       = (nxt_state == ST_AMBER) ? side_oh(nxt_side) : 4'b0000;
    nxt_preempt = emg_act && (nxt_state == ST_GREEN) && (nxt_side == emg_side);
  end

  assign R = ~(G | O);

endmodule

// File: tb/tb_tlc_sched.sv
// Directed bench for tlc_sched with default dwells (green 50, amber 5, all-red 2).
// Latency: observes outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tlc_sched;

  logic       clkdiv = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       emg_req;
  logic [1:0] emg_side;
  logic [3:0] G, O, R;
  logic [1:0] side;
  logic       preempt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clkdiv = ~clkdiv;

  tlc_sched #(
    .GREEN_T  (50),
    .AMBER_T  (5),
    .ALLRED_T (2)
  ) dut (
    .clkdiv   (clkdiv),
    .rst      (rst),
    .req      (req),
    .emg_req  (emg_req),
    .emg_side (emg_side),
    .G        (G),
    .O        (O),
    .R        (R),
    .side     (side),
    .preempt  (preempt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkdiv);
      #1;
    end
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    req      = 4'b0000;
    emg_req  = 1'b0;
    emg_side = 2'd0;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;

    // Reset state and quiet idle.
    do_reset();
    chk("rst_G", G, 4'b0000);
    chk("rst_O", O, 4'b0000);
    chk("rst_R", R, 4'b1111);
    chk("rst_side", side, 2'd0);
    chk("rst_preempt", preempt, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_R", R, 4'b1111);
      chk("idle_GO", {G, O}, 8'h00);
    end

    // Single requester: two all-red cycles, then held green with extensions.
    req = 4'b0001;
    tick(1);
    chk("solo_allred1", R, 4'b1111);
    tick(1);
    chk("solo_allred2", R, 4'b1111);
    tick(1);
    chk("solo_green", G, 4'b0001);
    chk("solo_side", side, 2'd0);
    tick(10);
    req = 4'b0101;              // one-cycle pulse far from expiry
    tick(1);
    req = 4'b0001;
    for (int i = 0; i < 120; i++) begin
      tick(1);
      chk("solo_hold_G", G, 4'b0001);
      chk("solo_hold_O", O, 4'b0000);
    end

    // All sides requesting: 0,1,2,3,0 with 50/5/2 phases.
    do_reset();
    req = 4'b1111;
    tick(2);
    for (int s = 0; s < 4; s++) begin
      oh = 4'b0001 << s;
      for (int i = 0; i < 50; i++) begin
        tick(1);
        chk($sformatf("rr_G_s%0d", s), G, oh);
        chk($sformatf("rr_O_s%0d", s), O, 4'b0000);
      end
      chk($sformatf("rr_side_s%0d", s), side, s);
      for (int i = 0; i < 5; i++) begin
        tick(1);
        chk($sformatf("rr_amber_s%0d", s), {G, O}, {4'b0000, oh});
      end
      for (int i = 0; i < 2; i++) begin
        tick(1);
        chk($sformatf("rr_allred_s%0d", s), R, 4'b1111);
      end
    end
    tick(1);
    chk("rr_wrap_G", G, 4'b0001);
    chk("rr_wrap_side", side, 2'd0);

    // Reset in the middle of side 1 amber.
    tick(49 + 5 + 2 + 1);
    chk("mid_green1", G, 4'b0010);
    tick(49 + 2);
    chk("mid_amber1", O, 4'b0010);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b0000;
    chk("mid_rst_R", R, 4'b1111);
    chk("mid_rst_GO", {G, O}, 8'h00);
    chk("mid_rst_side", side, 2'd0);
    tick(3);
    chk("mid_rst_idle", R, 4'b1111);
    // Pointer back at 3: side 0 beats side 3.
    req = 4'b1001;
    tick(3);
    chk("ptr_rst_G", G, 4'b0001);
    chk("ptr_rst_side", side, 2'd0);

`ifdef TLC_SCHED_EMG_EN
    // Emergency preempts side 0 green in favour of side 2.
    do_reset();
    req = 4'b0001;
    tick(3);
    tick(10);
    emg_req  = 1'b1;
    emg_side = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("emg_amber", {G, O}, {4'b0000, 4'b0001});
    end
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("emg_allred", R, 4'b1111);
    end
    tick(1);
    chk("emg_green", G, 4'b0100);
    chk("emg_side_out", side, 2'd2);
    for (int i = 0; i < 80; i++) begin
      tick(1);
      chk("emg_hold_G", G, 4'b0100);
      chk("emg_hold_pre", preempt, 1'b1);
    end
    emg_req = 1'b0;
    tick(1);
    chk("emg_rel_pre", preempt, 1'b0);
    chk("emg_rel_G", G, 4'b0100);
    for (int i = 0; i < 49; i++) begin
      tick(1);
      chk("emg_rel_hold", G, 4'b0100);
    end
    tick(1);
    chk("emg_rel_amber", O, 4'b0100);
`else
    // Emergency inputs have no effect.
    do_reset();
    emg_req  = 1'b1;
    emg_side = 2'd2;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("noemg_idle_R", R, 4'b1111);
      chk("noemg_idle_pre", preempt, 1'b0);
    end
    emg_req = 1'b0;
    req     = 4'b0001;
    tick(3);
    tick(10);
    emg_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("noemg_green_G", G, 4'b0001);
      chk("noemg_green_pre", preempt, 1'b0);
    end
    emg_req = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
